// File: rtl/uart_packets_to_bytes_pkg.sv
// Shared constants, FSM state type and escape helper for the packet-to-byte
// encoder.
package uart_packets_to_bytes_pkg;

  localparam logic [7:0] SOP_CHAR  = 8'h7A;
  localparam logic [7:0] EOP_CHAR  = 8'h7B;
  localparam logic [7:0] CHAN_CHAR = 8'h7C;
  localparam logic [7:0] ESC_CHAR  = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;

  typedef enum logic [2:0] {
    CHAN_MARK = 3'd0,
    CHAN_ESC  = 3'd1,
    CHAN_BYTE = 3'd2,
    SOP       = 3'd3,
    EOP       = 3'd4,
    DATA_ESC  = 3'd5,
    DATA      = 3'd6
  } p2b_state_e;

  // Bytes that collide with the framing characters must go out escaped.
  function automatic logic needs_escape(input logic [7:0] b);
    return (b >= SOP_CHAR) && (b <= ESC_CHAR);
  endfunction

endpackage

// File: rtl/uart_packets_to_bytes.sv
// Avalon-ST packet beats to escaped byte stream for a UART/JTAG byte sink.
// Optional macro P2B_CHANNEL_FIELD_EN: when defined, channel groups
// (0x7C + channel byte) are emitted whenever the channel changes or on the
// first beat after reset; when undefined, in_channel is ignored.
//
// state     | meaning
// ----------+-----------------------------------------------
// CHAN_MARK | sending channel marker 0x7C
// CHAN_ESC  | sending escape ahead of an escaped channel byte
// CHAN_BYTE | sending channel byte (XORed if escaped)
// SOP       | sending start-of-packet marker 0x7A
// EOP       | sending end-of-packet marker 0x7B
// DATA_ESC  | sending escape ahead of an escaped data byte
// DATA      | sending data byte (XORed if escaped); last byte of beat
//
// Beat start is not a stored state: when in_beat_q is clear the first state
// is chosen combinationally from the beat currently on the inputs, so no
// payload is ever latched.
import uart_packets_to_bytes_pkg::*;

module uart_packets_to_bytes (
  input  logic       clk,
  input  logic       reset_n,
  output logic       in_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic [7:0] in_channel,
  input  logic       in_startofpacket,
  input  logic       in_endofpacket,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data
);

  p2b_state_e state_q;
  p2b_state_e cur_state;
  p2b_state_e next_state;
  p2b_state_e data_first;
  p2b_state_e after_chan;
  p2b_state_e after_sop;
  logic       in_beat_q;
  logic       fire;
  logic       beat_done;
  logic       chan_taken;
  logic       data_esc;
  logic       need_chan;
  logic       chan_esc;
  logic [7:0] chan_byte;
  logic [7:0] byte_out;

`ifdef P2B_CHANNEL_FIELD_EN
  logic       chan_known_q;
  logic [7:0] last_chan_q;

  assign need_chan = !chan_known_q || (in_channel != last_chan_q);
  assign chan_esc  = needs_escape(in_channel);
  assign chan_byte = chan_esc ? (in_channel ^ ESC_XOR) : in_channel;

  // Remember the channel once its byte has actually been taken downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chan_known_q <= 1'b0;
      last_chan_q  <= 8'h00;
    end else if (fire && chan_taken) begin
      chan_known_q <= 1'b1;
      last_chan_q  <= in_channel;
    end
  end
`else
  logic unused_chan;

  assign need_chan   = 1'b0;
  assign chan_esc    = 1'b0;
  assign chan_byte   = 8'h00;
  assign unused_chan = ^{in_channel, chan_taken};
`endif

  // Handshake: outputs are forced quiet while reset is held.
  assign out_valid = in_valid && reset_n;
  assign fire      = out_valid && out_ready;
  assign in_ready  = fire && beat_done;
  assign out_data  = reset_n ? byte_out : 8'h00;

  // Choose the successor states from the current beat and the active state.
  always_comb begin
    data_esc   = needs_escape(in_data);
    data_first = data_esc ? DATA_ESC : DATA;
    after_sop  = in_endofpacket ? EOP : data_first;
    after_chan = in_startofpacket ? SOP : after_sop;
    if (in_beat_q) begin
      cur_state = state_q;
    end else if (need_chan) begin
      cur_state = CHAN_MARK;
    end else begin
      cur_state = after_chan;
    end
  end

  // Per-state output byte and next state.
  always_comb begin
    next_state = cur_state;
    byte_out   = 8'h00;
    beat_done  = 1'b0;
    chan_taken = 1'b0;
    case (cur_state)
      CHAN_MARK: begin
        byte_out   = CHAN_CHAR;
        next_state = chan_esc ? CHAN_ESC : CHAN_BYTE;
      end
      CHAN_ESC: begin
        byte_out   = ESC_CHAR;
        next_state = CHAN_BYTE;
      end
      CHAN_BYTE: begin
        byte_out   = chan_byte;
        chan_taken = 1'b1;
        next_state = after_chan;
      end
      SOP: begin
        byte_out   = SOP_CHAR;
        next_state = after_sop;
      end
      EOP: begin
        byte_out   = EOP_CHAR;
        next_state = data_first;
      end
      DATA_ESC: begin
        byte_out   = ESC_CHAR;
        next_state = DATA;
      end
      DATA: begin
        byte_out   = data_esc ? (in_data ^ ESC_XOR) : in_data;
        beat_done  = 1'b1;
        next_state = DATA;
      end
      default: begin
        byte_out   = 8'h00;
        next_state = DATA;
      end
    endcase
  end

  // Advance only on an accepted byte; the final byte returns to beat start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= CHAN_MARK;
      in_beat_q <= 1'b0;
    end else if (fire) begin
      if (beat_done) begin
        in_beat_q <= 1'b0;
      end else begin
        in_beat_q <= 1'b1;
        state_q   <= next_state;
      end
    end
  end

endmodule

// File: tb/tb_uart_packets_to_bytes.sv
// Directed bench for uart_packets_to_bytes; expectations follow the build's
// P2B_CHANNEL_FIELD_EN setting.
module tb_uart_packets_to_bytes;

  logic       clk;
  logic       reset_n;
  logic       in_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] in_channel;
  logic       in_startofpacket;
  logic       in_endofpacket;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  uart_packets_to_bytes dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_ready         (in_ready),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_channel       (in_channel),
    .in_startofpacket (in_startofpacket),
    .in_endofpacket   (in_endofpacket),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_data         (out_data)
  );

  always #5 clk = ~clk;

  // Outputs must be quiet while reset is held, even with a beat offered.
  task automatic check_reset(input string tag);
    @(negedge clk);
    checks++;
    assert (out_valid === 1'b0) else begin
      errors++; $error("FAIL %s out_valid got %b exp 0", tag, out_valid);
    end
    checks++;
    assert (in_ready === 1'b0) else begin
      errors++; $error("FAIL %s in_ready got %b exp 0", tag, in_ready);
    end
    checks++;
    assert (out_data === 8'h00) else begin
      errors++; $error("FAIL %s out_data got %02h exp 00", tag, out_data);
    end
  endtask

  // Offer one beat and check bytes against exp_q until 'stop' bytes accepted.
  // rdy/vld are 4-cycle repeating patterns for out_ready and in_valid.
  task automatic run_beat(input logic [7:0] ch, input logic s, input logic e,
                          input logic [7:0] d, input int stop,
                          input logic [3:0] rdy, input logic [3:0] vld,
                          input string tag);
    int idx;
    int cyc;
    int n;
    logic exp_rdy;
    idx = 0;
    cyc = 0;
    n = exp_q.size();
    in_channel = ch;
    in_startofpacket = s;
    in_endofpacket = e;
    in_data = d;
    while (idx < stop && cyc < 64) begin
      out_ready = rdy[cyc[1:0]];
      in_valid  = vld[cyc[1:0]];
      @(negedge clk);
      checks++;
      assert (out_valid === in_valid) else begin
        errors++; $error("FAIL %s out_valid cyc %0d got %b exp %b", tag, cyc, out_valid, in_valid);
      end
      if (in_valid) begin
        checks++;
        assert (out_data === exp_q[idx]) else begin
          errors++; $error("FAIL %s out_data byte %0d got %02h exp %02h", tag, idx, out_data, exp_q[idx]);
        end
      end
      exp_rdy = in_valid && out_ready && (idx == n - 1);
      checks++;
      assert (in_ready === exp_rdy) else begin
        errors++; $error("FAIL %s in_ready byte %0d got %b exp %b", tag, idx, in_ready, exp_rdy);
      end
      if (in_valid && out_ready) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    assert (idx == stop) else begin
      errors++; $error("FAIL %s timeout bytes got %0d exp %0d", tag, idx, stop);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    reset_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_channel = 8'h00;
    in_startofpacket = 1'b1;
    in_endofpacket = 1'b1;
    in_data = 8'h41;
    #2;
    check_reset("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

`ifdef P2B_CHANNEL_FIELD_EN
    exp_q = '{8'h7C, 8'h00, 8'h7A, 8'h7B, 8'h41};
`else
    exp_q = '{8'h7A, 8'h7B, 8'h41};
`endif
    run_beat(8'h00, 1'b1, 1'b1, 8'h41, exp_q.size(), 4'b1111, 4'b1111, "first_beat");

    exp_q = '{8'h7A, 8'h10};
    run_beat(8'h00, 1'b1, 1'b0, 8'h10, exp_q.size(), 4'b1111, 4'b1111, "pkt_sop");
    exp_q = '{8'h7B, 8'h7D, 8'h5B};
    run_beat(8'h00, 1'b0, 1'b1, 8'h7B, exp_q.size(), 4'b1111, 4'b1111, "pkt_eop_esc");

`ifdef P2B_CHANNEL_FIELD_EN
    exp_q = '{8'h7C, 8'h7D, 8'h5D, 8'h7A, 8'h7B, 8'h55};
`else
    exp_q = '{8'h7A, 8'h7B, 8'h55};
`endif
    run_beat(8'h7D, 1'b1, 1'b1, 8'h55, exp_q.size(), 4'b1111, 4'b1111, "chan_esc");

`ifdef P2B_CHANNEL_FIELD_EN
    exp_q = '{8'h7C, 8'h05, 8'h20};
`else
    exp_q = '{8'h20};
`endif
    run_beat(8'h05, 1'b0, 1'b0, 8'h20, exp_q.size(), 4'b1111, 4'b1101, "valid_gap");

    exp_q = '{8'h7D, 8'h5A};
    run_beat(8'h05, 1'b0, 1'b0, 8'h7A, exp_q.size(), 4'b1111, 4'b1111, "same_chan_data_esc");

`ifdef P2B_CHANNEL_FIELD_EN
    exp_q = '{8'h7C, 8'h7D, 8'h5A, 8'h7A, 8'h7B, 8'h7D, 8'h5C};
`else
    exp_q = '{8'h7A, 8'h7B, 8'h7D, 8'h5C};
`endif
    run_beat(8'h7A, 1'b1, 1'b1, 8'h7C, exp_q.size(), 4'b1111, 4'b1111, "max_len");

    reset_n = 1'b0;
    in_valid = 1'b1;
    check_reset("reset2");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
`ifdef P2B_CHANNEL_FIELD_EN
    exp_q = '{8'h7C, 8'h00, 8'h7A, 8'h7B, 8'h41};
`else
    exp_q = '{8'h7A, 8'h7B, 8'h41};
`endif
    run_beat(8'h00, 1'b1, 1'b1, 8'h41, exp_q.size(), 4'b1001, 4'b1111, "stall");

    reset_n = 1'b0;
    in_valid = 1'b1;
    check_reset("reset3");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
`ifdef P2B_CHANNEL_FIELD_EN
    run_beat(8'h00, 1'b1, 1'b1, 8'h41, 3, 4'b1111, 4'b1111, "partial");
`else
    run_beat(8'h00, 1'b1, 1'b1, 8'h41, 1, 4'b1111, 4'b1111, "partial");
`endif
    reset_n = 1'b0;
    in_valid = 1'b1;
    check_reset("mid_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_beat(8'h00, 1'b1, 1'b1, 8'h41, exp_q.size(), 4'b1111, 4'b1111, "replay");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
